// File: rtl/bch_encode_pkg.sv
// Shared BCH definitions: FSM state type, GF(2^M) arithmetic and generator
// polynomial construction evaluated at elaboration time (supports M = 2..8).
package bch_encode_pkg;

  localparam int MAX_M   = 8;
  localparam int MAX_ECC = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_DONE
  } state_e;

  function automatic int prim_poly(input int m);
    case (m)
      2:       return 'h7;
      3:       return 'hB;
      4:       return 'h13;
      5:       return 'h25;
      6:       return 'h43;
      7:       return 'h89;
      8:       return 'h11D;
      default: return 0;
    endcase
  endfunction

  function automatic int gf_mul(input int a, input int b, input int m);
    int p;
    int x;
    p = 0;
    x = a;
    for (int i = 0; i < m; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x = x ^ prim_poly(m);
    end
    return p;
  endfunction

  // alpha^k in the polynomial basis.
  function automatic int lpow(input int k, input int m);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = gf_mul(r, 2, m);
    return r;
  endfunction

  // g(x) = product of (x + alpha^j) over the union of the cyclotomic cosets
  // of 1..2T, i.e. the LCM of the minimal polynomials. Coefficients of the
  // result collapse to GF(2), so only bit 0 of each one is kept.
  function automatic logic [MAX_ECC:0] bch_generator(input int m, input int t);
    int                          n;
    int                          j;
    int                          a;
    int                          deg;
    logic [(1<<MAX_M)-1:0]       root;
    logic [8*(MAX_ECC+1)-1:0]    c;
    logic [MAX_ECC:0]            g;
    n      = (1 << m) - 1;
    root   = '0;
    c      = '0;
    c[7:0] = 8'd1;
    deg    = 0;
    for (int i = 1; i <= 2 * t; i++) begin
      j = i % n;
      for (int s = 0; s < m; s++) begin
        if (!root[j] && deg < MAX_ECC) begin
          root[j] = 1'b1;
          a       = lpow(j, m);
          for (int k = deg + 1; k >= 1; k--)
            c[k*8 +: 8] = c[(k-1)*8 +: 8] ^ 8'(gf_mul(int'(c[k*8 +: 8]), a, m));
          c[7:0] = 8'(gf_mul(int'(c[7:0]), a, m));
          deg++;
        end
        j = (2 * j) % n;
      end
    end
    g = '0;
    for (int k = 0; k <= MAX_ECC; k++) g[k] = c[k*8];
    return g;
  endfunction

  function automatic int bch_ecc_bits(input int m, input int t);
    logic [MAX_ECC:0] g;
    int               d;
    g = bch_generator(m, t);
    d = 0;
    for (int k = 0; k <= MAX_ECC; k++)
      if (g[k]) d = k;
    return d;
  endfunction

endpackage

// File: rtl/bch_encode_lfsr.sv
// Division-by-g(x) shift register. With fb_en low it shifts out the remainder
// MSB-first with zero fill.
module bch_encode_lfsr
  import bch_encode_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic shift,
  input  logic fb_en,
  input  logic in_bit,
  output logic msb
);

  localparam logic [MAX_ECC:0] GEN      = bch_generator(M, T);
  localparam int               ECC_BITS = bch_ecc_bits(M, T);
  localparam logic [ECC_BITS-1:0] G_LOW = GEN[ECC_BITS-1:0];

  logic [ECC_BITS-1:0] rem;
  logic                fb;

  assign fb  = fb_en & (in_bit ^ rem[ECC_BITS-1]);
  assign msb = rem[ECC_BITS-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (clear) begin
      rem <= '0;
    end else if (shift) begin
      rem <= {rem[ECC_BITS-2:0], 1'b0} ^ (fb ? G_LOW : '0);
    end
  end

endmodule

// File: rtl/bch_encode.sv
// Bit-serial systematic BCH encoder: message bits pass through, then parity.
// Optional build macro BCH_ENCODE_PARITY_INV_EN inverts parity bits on output.
module bch_encode
  import bch_encode_pkg::*;
#(
  parameter int M         = 4,
  parameter int T         = 3,
  parameter int DATA_BITS = (1 << M) - 1 - bch_ecc_bits(M, T)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  input  logic in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last
);

  localparam int N        = (1 << M) - 1;
  localparam int ECC_BITS = bch_ecc_bits(M, T);
  localparam int CNT_MAX  = (DATA_BITS > ECC_BITS) ? DATA_BITS : ECC_BITS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

`ifdef BCH_ENCODE_PARITY_INV_EN
  localparam logic PARITY_XOR = 1'b1;
`else
  localparam logic PARITY_XOR = 1'b0;
`endif

  if (M < 2 || M > MAX_M) begin : g_bad_m
    $error("bch_encode: M out of supported range");
  end
  if (DATA_BITS < 1 || DATA_BITS > N - ECC_BITS) begin : g_bad_data_bits
    $error("bch_encode: DATA_BITS must be in 1..N-ECC_BITS");
  end

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             out_free;
  logic             load, load_bit, load_last;
  logic             lfsr_clear, lfsr_shift, lfsr_fb_en, lfsr_msb;

  bch_encode_lfsr #(.M(M), .T(T)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (lfsr_clear),
    .shift  (lfsr_shift),
    .fb_en  (lfsr_fb_en),
    .in_bit (in_data),
    .msb    (lfsr_msb)
  );

  assign out_free = !out_valid || out_ready;
  assign busy     = (state != ST_IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    in_ready   = 1'b0;
    load       = 1'b0;
    load_bit   = 1'b0;
    load_last  = 1'b0;
    lfsr_clear = 1'b0;
    lfsr_shift = 1'b0;
    lfsr_fb_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DATA;
          cnt_d      = '0;
          lfsr_clear = 1'b1;
        end
      end
      ST_DATA: begin
        in_ready = out_free;
        if (in_valid && out_free) begin
          load       = 1'b1;
          load_bit   = in_data;
          lfsr_shift = 1'b1;
          lfsr_fb_en = 1'b1;
          if (cnt == CNT_W'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (out_free) begin
          load       = 1'b1;
          load_bit   = lfsr_msb ^ PARITY_XOR;
          lfsr_shift = 1'b1;
          cnt_d      = cnt + CNT_W'(1);
          if (cnt == CNT_W'(ECC_BITS - 1)) begin
            load_last = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Only the final parity bit can be pending here.
        if (out_valid && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_bit;
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bch_encode.sv
// Directed bench for bch_encode: full-length (15,5) code and a shortened
// DATA_BITS=3 instance, with stalls, ignored starts and a mid-codeword reset.
module tb_bch_encode;

`ifdef BCH_ENCODE_PARITY_INV_EN
  localparam logic [9:0] PMASK = 10'h3FF;
`else
  localparam logic [9:0] PMASK = 10'h000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic in_data, in_valid, out_ready;
  logic busy_a, in_ready_a, out_data_a, out_valid_a, out_last_a;
  logic busy_b, in_ready_b, out_data_b, out_valid_b, out_last_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bch_encode #(.M(4), .T(3)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .busy      (busy_a),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .out_data  (out_data_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_last  (out_last_a)
  );

  bch_encode #(.M(4), .T(3), .DATA_BITS(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .busy      (busy_b),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .out_data  (out_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_last  (out_last_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel_b, input logic v);
    if (sel_b) start_b = v;
    else       start_a = v;
  endtask

  // mode 0: in_valid/out_ready held high; mode 1: gaps on both sides plus
  // start pulses while busy.
  task automatic encode(input bit sel_b, input logic [4:0] msg, input int nbits,
                        input int mode, input logic [14:0] exp_cw, input int exp_len,
                        input string tag);
    int          idx, cyc, nout, last_pos, first_acc, last_cyc;
    bit          done;
    logic [14:0] got;
    logic        ir, ov, od, ol, bz;
    @(negedge clk);
    set_start(sel_b, 1'b1);
    @(negedge clk);
    set_start(sel_b, 1'b0);
    #1;
    bz = sel_b ? busy_b : busy_a;
    check({tag, " busy after start"}, 32'(bz), 32'd1);
    idx = 0; cyc = 0; nout = 0; last_pos = -1; first_acc = -1; last_cyc = -1;
    done = 1'b0; got = '0;
    while (!done && cyc < 400) begin
      in_valid  = (idx < nbits) && (mode == 0 || (cyc % 3) != 1);
      in_data   = in_valid ? msg[nbits-1-idx] : 1'b0;
      out_ready = (mode == 0) || ((cyc % 4) != 2);
      set_start(sel_b, (mode != 0) && ((cyc % 5) == 3));
      #1;
      ir = sel_b ? in_ready_b  : in_ready_a;
      ov = sel_b ? out_valid_b : out_valid_a;
      od = sel_b ? out_data_b  : out_data_a;
      ol = sel_b ? out_last_b  : out_last_a;
      if (in_valid && ir) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (ov && out_ready) begin
        got = {got[13:0], od};
        nout++;
        if (ol) begin
          last_pos = nout;
          last_cyc = cyc;
          done     = 1'b1;
          // A start on the returning-to-IDLE edge must not be taken.
          set_start(sel_b, 1'b1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    set_start(sel_b, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    bz = sel_b ? busy_b : busy_a;
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " codeword"}, 32'(got), 32'(exp_cw));
    check({tag, " bit count"}, 32'(nout), 32'(exp_len));
    check({tag, " out_last position"}, 32'(last_pos), 32'(exp_len));
    check({tag, " idle after last"}, 32'(bz), 32'd0);
    if (mode == 0)
      check({tag, " last cycle after first accept"}, 32'(last_cyc - first_acc), 32'(exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    in_data = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset busy",      32'(busy_a),      32'd0);
    check("reset in_ready",  32'(in_ready_a),  32'd0);
    check("reset out_valid", 32'(out_valid_a), 32'd0);
    check("reset out_data",  32'(out_data_a),  32'd0);
    check("reset out_last",  32'(out_last_a),  32'd0);
    rst_n = 1'b1;

    // Parity constants are x^k mod g(x) combinations with g = 0x537.
    encode(1'b0, 5'b00000, 5, 0, {5'b00000, 10'h000 ^ PMASK}, 15, "zero");
    encode(1'b0, 5'b00001, 5, 0, {5'b00001, 10'h137 ^ PMASK}, 15, "g");
    encode(1'b0, 5'b11111, 5, 0, {5'b11111, 10'h3FF ^ PMASK}, 15, "ones");
    encode(1'b0, 5'b10000, 5, 1, {5'b10000, 10'h29B ^ PMASK}, 15, "x14 gaps");
    encode(1'b0, 5'b10101, 5, 1, {5'b10101, 10'h247 ^ PMASK}, 15, "10101 gaps");
    encode(1'b0, 5'b01010, 5, 1, {5'b01010, 10'h1B8 ^ PMASK}, 15, "01010 gaps");

    // Abandon a codeword after three data bits.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("pre-reset out_valid", 32'(out_valid_a), 32'd1);
    check("pre-reset in_ready",  32'(in_ready_a),  32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid_a), 32'd0);
    check("async reset busy",      32'(busy_a),      32'd0);
    check("async reset in_ready",  32'(in_ready_a),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    encode(1'b0, 5'b00001, 5, 0, {5'b00001, 10'h137 ^ PMASK}, 15, "g after reset");

    encode(1'b1, 5'b00001, 3, 0, {2'b00, 3'b001, 10'h137 ^ PMASK}, 13, "short 001");
    encode(1'b1, 5'b00100, 3, 1, {2'b00, 3'b100, 10'h1EB ^ PMASK}, 13, "short 100 gaps");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_encode.md
Name: bch_encode

Overview:
- Bit-serial systematic binary BCH encoder.
- Transmit-side counterpart of the syndrome/Chien-search decode path.
- Accepts DATA_BITS message bits MSB-first and passes them through unchanged.
- Divides the message by the generator polynomial g(x) in an LFSR, then shifts out the ECC_BITS remainder (parity) bits MSB-first, so the codeword stream feeds the channel/storage model directly.

Parameters:
- M, 4, field degree; code length N = 2^M-1.
- T, 3, correctable bits; generator = LCM of minimal polynomials of alpha^1..alpha^(2T).
- DATA_BITS, N-ECC_BITS (5 for defaults), message length; values below the maximum give a shortened code. Elaboration error if 0 or greater than N-ECC_BITS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin codeword; honoured only in IDLE
- busy  out  1  high from accepted start until last parity bit handshaken
- in_data  in  1  message bit
- in_valid  in  1  message bit present
- in_ready  out  1  encoder accepts message bit this cycle
- out_data  out  1  codeword bit
- out_valid  out  1  codeword bit present
- out_ready  in  1  downstream accepts codeword bit
- out_last  out  1  qualifies final parity bit

Behaviour:
- Reset (async assert, sync deassert by clk): state IDLE, LFSR=0, counter=0, busy=0, in_ready=0, out_valid=0, out_data=0, out_last=0. Reset mid-codeword abandons it; no partial output follows.
- ECC_BITS = degree of g(x), computed at elaboration; M=4,T=3 gives g = 0x537, ECC_BITS=10.
- Single output register. out_free = !out_valid || out_ready.
- States:
  - IDLE: start=1 -> DATA, counter=0, LFSR=0; busy=1 next cycle.
  - DATA: in_ready = out_free.
    - On in_valid && in_ready: out_data<=in_data, out_valid<=1, fb=in_data^LFSR[ECC_BITS-1], LFSR<=(LFSR<<1) ^ (fb ? g[ECC_BITS-1:0] : 0), counter++.
    - After bit DATA_BITS-1 accepted: -> PARITY, counter=0.
  - PARITY: in_ready=0.
    - When out_free: out_data<=LFSR[ECC_BITS-1], LFSR<<=1 (zero fill), out_valid<=1, counter++.
    - out_last<=1 with bit ECC_BITS-1. Next state after that load is DONE.
  - DONE: hold until the last bit is handshaken, then -> IDLE with busy=0 in the same edge.
- Otherwise out_valid clears when handshaken and nothing new is loaded.
- Latency: each message bit appears on out_data one cycle after acceptance. Full rate (1 bit/clk) with out_ready held high; no bubble between data and parity.
- start ignored outside IDLE. start in the same cycle the IDLE transition occurs is not accepted; it is accepted from IDLE on the following cycle.
- in_valid while in_ready=0 is ignored; in_data is not sampled.
- Counter width clog2(max(DATA_BITS,ECC_BITS)+1); no wrap within a codeword.

Optional Feature:
- Macro BCH_ENCODE_PARITY_INV_EN.
- Defined: parity bits are inverted at output load, so an all-ones message (erased flash page) yields all-zero parity. The LFSR itself is not inverted.
- Undefined: plain parity.
- Data bits are never inverted.

Decomposition:
- Shared header (bch.vh, already shared with the decoder) holds:
  - Field functions lpow and minimal-polynomial computation.
  - New functions bch_generator(M,T) returning g(x) and bch_ecc_bits(M,T) returning its degree.
- One natural sub-module, bch_encode_lfsr: parameterised by M,T; inputs clk, rst_n, clear, shift, fb_en, in_bit; output remainder MSB. It is reused later for parallel encoding.
- The FSM, counter and handshake stay in bch_encode.

Test Plan:
- All-zero message 00000, out_ready=1: codeword 15 zeros. out_last on cycle 15 after first acceptance, then busy=0.
- Message 00001: codeword 000010100110111 (equals g). Decoder syndromes are all zero.
- Message 11111: parity 1111111111. With BCH_ENCODE_PARITY_INV_EN defined: parity 0000000000.
- Random 1000 messages with random in_valid/out_ready gaps: stream equals the software model. No bit duplicated or dropped while out_valid && !out_ready. start pulses during busy have no effect.
- rst_n asserted after 3 data bits: out_valid, busy and in_ready fall asynchronously. A following start with 00001 yields the correct codeword.
- DATA_BITS=3 (shortened), message 001: codeword 0010100110111; out_last on the 13th bit.
